// File: rtl/micro_pkg.sv
// Shared definitions for the parametrised accumulator core: opcode map and
// control-state encoding.
package micro_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDA  = 4'h1;
    localparam logic [OPC_W-1:0] OP_STA  = 4'h2;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'h3;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h4;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h5;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h6;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'h7;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'h8;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'h9;
    localparam logic [OPC_W-1:0] OP_JZ   = 4'hA;
    localparam logic [OPC_W-1:0] OP_JC   = 4'hB;
    localparam logic [OPC_W-1:0] OP_CALL = 4'hC;
    localparam logic [OPC_W-1:0] OP_RET  = 4'hD;
    localparam logic [OPC_W-1:0] OP_NOT  = 4'hE;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        S_EXEC     = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_t;

endpackage

// File: rtl/micro_ret_stack.sv
// Return-address LIFO for CALL/RET. Push/pop are ignored when full/empty;
// the core treats those cases as fatal before they reach here.
module micro_ret_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign wr_idx = IDX_W'(cnt_q);
    assign rd_idx = IDX_W'(cnt_q - CNT_W'(1));
    assign full   = (cnt_q == CNT_W'(STACK_DEPTH));
    assign empty  = (cnt_q == '0);
    assign dout   = mem[rd_idx];

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_q <= '0;
        end else if (push && !full) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (pop && !empty) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Storage needs no reset: the entry count alone defines what is valid.
    always_ff @(posedge Clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/micro_acc_core_p.sv
// Parametrised accumulator microprocessor with handshaked data memory,
// Z/C flags, conditional jumps and a hardware return stack.
module micro_acc_core_p
    import micro_pkg::*;
#(
    parameter  int DATA_W      = 8,
    parameter  int ADDR_W      = 8,
    parameter  int STACK_DEPTH = 4,
    localparam int INSTR_W     = OPC_W + ADDR_W
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [INSTR_W-1:0] Instrucciones,
    input  logic [DATA_W-1:0]  Datos_Entrada,
    input  logic               Mem_Ack,
    output logic [ADDR_W-1:0]  Direccion_Instrucciones,
    output logic [ADDR_W-1:0]  Direccion_Datos,
    output logic [DATA_W-1:0]  Salida_Datos,
    output logic               RW,
    output logic               Mem_Req,
    output logic [DATA_W-1:0]  Acc_Out,
    output logic               Flag_Z,
    output logic               Flag_C,
    output logic               Halted,
    output logic               Stack_Err
);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic               z_q, z_d;
    logic               c_q, c_d;
    logic [ADDR_W-1:0]  daddr_q, daddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               rw_q, rw_d;
    logic               req_q, req_d;
    logic               halted_q, halted_d;
    logic               serr_q, serr_d;
    logic [OPC_W-1:0]   op_q, op_d;

    logic [OPC_W-1:0]   opc;
    logic [ADDR_W-1:0]  operand;
    logic [ADDR_W-1:0]  pc_inc;
    logic [DATA_W-1:0]  ldi_val;
    logic [DATA_W:0]    alu_res;

    logic               stk_push;
    logic               stk_pop;
    logic [ADDR_W-1:0]  stk_dout;
    logic               stk_full;
    logic               stk_empty;

    // Result of a memory-operand op; bit DATA_W carries out of ADD or
    // borrows out of SUB and is meaningless for the logic ops.
    function automatic logic [DATA_W:0] alu_mem(
        input logic [OPC_W-1:0]  op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W:0] r;
        r = {1'b0, b};
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            default: r = {1'b0, b};
        endcase
        return r;
    endfunction

    assign opc     = Instrucciones[INSTR_W-1 -: OPC_W];
    assign operand = Instrucciones[ADDR_W-1:0];
    assign pc_inc  = pc_q + ADDR_W'(1);
    assign ldi_val = DATA_W'(operand);
    assign alu_res = alu_mem(op_q, acc_q, Datos_Entrada);

    micro_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        acc_d    = acc_q;
        z_d      = z_q;
        c_d      = c_q;
        daddr_d  = daddr_q;
        wdata_d  = wdata_q;
        rw_d     = rw_q;
        req_d    = req_q;
        halted_d = halted_q;
        serr_d   = serr_q;
        op_d     = op_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;

        case (state_q)
            S_EXEC: begin
                case (opc)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        req_d   = 1'b1;
                        daddr_d = operand;
                        rw_d    = (opc != OP_STA);
                        op_d    = opc;
                        if (opc == OP_STA) begin
                            wdata_d = acc_q;
                        end
                        state_d = S_MEM_WAIT;
                    end
                    OP_LDI: begin
                        acc_d = ldi_val;
                        z_d   = (ldi_val == '0);
                        pc_d  = pc_inc;
                    end
                    OP_JMP: pc_d = operand;
                    OP_JZ:  pc_d = z_q ? operand : pc_inc;
                    OP_JC:  pc_d = c_q ? operand : pc_inc;
                    OP_CALL: begin
                        if (stk_full) begin
                            serr_d   = 1'b1;
                            halted_d = 1'b1;
                            state_d  = S_HALT;
                        end else begin
                            stk_push = 1'b1;
                            pc_d     = operand;
                        end
                    end
                    OP_RET: begin
                        if (stk_empty) begin
                            serr_d   = 1'b1;
                            halted_d = 1'b1;
                            state_d  = S_HALT;
                        end else begin
                            stk_pop = 1'b1;
                            pc_d    = stk_dout;
                        end
                    end
                    OP_NOT: begin
                        acc_d = ~acc_q;
                        z_d   = (acc_q == '1);
                        pc_d  = pc_inc;
                    end
                    OP_HALT: begin
                        halted_d = 1'b1;
                        req_d    = 1'b0;
                        state_d  = S_HALT;
                    end
                    default: pc_d = pc_inc;
                endcase
            end
            S_MEM_WAIT: begin
                // Request lines stay frozen until the acknowledging edge.
                if (Mem_Ack) begin
                    req_d   = 1'b0;
                    rw_d    = 1'b1;
                    pc_d    = pc_inc;
                    state_d = S_EXEC;
                    if (op_q != OP_STA) begin
                        acc_d = alu_res[DATA_W-1:0];
                        z_d   = (alu_res[DATA_W-1:0] == '0);
                    end
                    if (op_q == OP_ADD || op_q == OP_SUB) begin
                        c_d = alu_res[DATA_W];
                    end
                end
            end
            S_HALT: begin
                req_d = 1'b0;
            end
            default: state_d = S_EXEC;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= S_EXEC;
            pc_q     <= '0;
            acc_q    <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            daddr_q  <= '0;
            wdata_q  <= '0;
            rw_q     <= 1'b1;
            req_q    <= 1'b0;
            halted_q <= 1'b0;
            serr_q   <= 1'b0;
            op_q     <= OP_NOP;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            z_q      <= z_d;
            c_q      <= c_d;
            daddr_q  <= daddr_d;
            wdata_q  <= wdata_d;
            rw_q     <= rw_d;
            req_q    <= req_d;
            halted_q <= halted_d;
            serr_q   <= serr_d;
            op_q     <= op_d;
        end
    end

    assign Direccion_Instrucciones = pc_q;
    assign Direccion_Datos         = daddr_q;
    assign Salida_Datos            = wdata_q;
    assign RW                      = rw_q;
    assign Mem_Req                 = req_q;
    assign Acc_Out                 = acc_q;
    assign Flag_Z                  = z_q;
    assign Flag_C                  = c_q;
    assign Halted                  = halted_q;
    assign Stack_Err               = serr_q;

endmodule

// File: tb/tb_micro_acc_core_p.sv
// Directed bench for micro_acc_core_p: ROM/data-memory models driven by the
// bench, memory transactions scored against an expectation queue.
module tb_micro_acc_core_p;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 12;

    logic               Clk = 1'b0;
    logic               Rst = 1'b1;
    logic [INSTR_W-1:0] Instrucciones;
    logic [DATA_W-1:0]  Datos_Entrada;
    logic               Mem_Ack = 1'b0;
    logic [ADDR_W-1:0]  Direccion_Instrucciones;
    logic [ADDR_W-1:0]  Direccion_Datos;
    logic [DATA_W-1:0]  Salida_Datos;
    logic               RW;
    logic               Mem_Req;
    logic [DATA_W-1:0]  Acc_Out;
    logic               Flag_Z;
    logic               Flag_C;
    logic               Halted;
    logic               Stack_Err;

    logic [INSTR_W-1:0] rom  [256];
    logic [DATA_W-1:0]  dmem [256];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] addr;
        logic       rw;
        logic [7:0] data;
    } mem_exp_t;

    mem_exp_t exp_q[$];

    micro_acc_core_p #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (4)
    ) dut (
        .Clk                     (Clk),
        .Rst                     (Rst),
        .Instrucciones           (Instrucciones),
        .Datos_Entrada           (Datos_Entrada),
        .Mem_Ack                 (Mem_Ack),
        .Direccion_Instrucciones (Direccion_Instrucciones),
        .Direccion_Datos         (Direccion_Datos),
        .Salida_Datos            (Salida_Datos),
        .RW                      (RW),
        .Mem_Req                 (Mem_Req),
        .Acc_Out                 (Acc_Out),
        .Flag_Z                  (Flag_Z),
        .Flag_C                  (Flag_C),
        .Halted                  (Halted),
        .Stack_Err               (Stack_Err)
    );

    assign Instrucciones = rom[Direccion_Instrucciones];
    assign Datos_Entrada = dmem[Direccion_Datos];

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] pc, input logic [7:0] acc,
                             input logic z, input logic c);
        chk({tag, "_pc"},  32'(Direccion_Instrucciones), 32'(pc));
        chk({tag, "_acc"}, 32'(Acc_Out), 32'(acc));
        chk({tag, "_z"},   32'(Flag_Z), 32'(z));
        chk({tag, "_c"},   32'(Flag_C), 32'(c));
    endtask

    task automatic expect_mem(input logic [7:0] addr, input logic rw, input logic [7:0] data);
        mem_exp_t e;
        e.addr = addr;
        e.rw   = rw;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic chk_mem_issue(input string tag);
        mem_exp_t e;
        chk({tag, "_req"}, 32'(Mem_Req), 32'(1));
        chk({tag, "_sb"}, 32'(exp_q.size() > 0), 32'(1));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_addr"}, 32'(Direccion_Datos), 32'(e.addr));
            chk({tag, "_rw"}, 32'(RW), 32'(e.rw));
            if (!e.rw) begin
                chk({tag, "_wdata"}, 32'(Salida_Datos), 32'(e.data));
            end
        end
    endtask

    task automatic reset_assert(input string tag);
        Rst = 1'b0;
        #1;
        chk({tag, "_pc"},    32'(Direccion_Instrucciones), 32'(0));
        chk({tag, "_dbus"},  32'({Direccion_Datos, Salida_Datos, Acc_Out}), 32'(0));
        chk({tag, "_ctl"},   32'({Mem_Req, Flag_Z, Flag_C, Halted, Stack_Err}), 32'(0));
        chk({tag, "_rw"},    32'(RW), 32'(1));
    endtask

    task automatic reset_release(input string tag);
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        chk({tag, "_pc0"}, 32'(Direccion_Instrucciones), 32'(0));
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 12'h000;
    endtask

    logic [7:0] call_trace [13] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h41, 8'h31,
                                    8'h21, 8'h11, 8'h60, 8'h61, 8'h62, 8'h63};

    initial begin
        clear_rom();
        for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
        dmem[8'h10] = 8'h20;
        dmem[8'h11] = 8'h01;
        dmem[8'h12] = 8'h00;

        rom[8'h00] = 12'h8F0;
        rom[8'h01] = 12'h310;
        rom[8'h02] = 12'h85A;
        rom[8'h03] = 12'h233;
        rom[8'h04] = 12'h410;
        rom[8'h05] = 12'h800;
        rom[8'h06] = 12'hA40;
        rom[8'h40] = 12'hB80;
        rom[8'h41] = 12'hE00;
        rom[8'h42] = 12'h311;
        rom[8'h43] = 12'hB50;
        rom[8'h50] = 12'h411;
        rom[8'h51] = 12'h112;
        rom[8'h52] = 12'h310;

        Mem_Ack = 1'b1;
        #1;
        reset_assert("por");
        reset_release("por");

        tick(); chk_state("ldi_f0", 8'h01, 8'hF0, 1'b0, 1'b0);
        expect_mem(8'h10, 1'b1, 8'h00);
        tick(); chk_mem_issue("add_issue");
        chk("add_pc_hold", 32'(Direccion_Instrucciones), 32'(8'h01));
        tick(); chk_state("add", 8'h02, 8'h10, 1'b0, 1'b1);
        chk("add_req_drop", 32'(Mem_Req), 32'(0));
        tick(); chk_state("ldi_5a", 8'h03, 8'h5A, 1'b0, 1'b1);

        Mem_Ack = 1'b0;
        expect_mem(8'h33, 1'b0, 8'h5A);
        tick(); chk_mem_issue("sta_issue");
        chk("sta_pc_hold", 32'(Direccion_Instrucciones), 32'(8'h03));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sta_hold", 32'({Mem_Req, RW, Direccion_Datos, Salida_Datos, Direccion_Instrucciones}),
                32'({1'b1, 1'b0, 8'h33, 8'h5A, 8'h03}));
        end
        Mem_Ack = 1'b1;
        tick(); chk_state("sta_done", 8'h04, 8'h5A, 1'b0, 1'b1);
        chk("sta_req_drop", 32'(Mem_Req), 32'(0));

        expect_mem(8'h10, 1'b1, 8'h00);
        tick(); chk_mem_issue("sub_issue");
        tick(); chk_state("sub", 8'h05, 8'h3A, 1'b0, 1'b0);
        tick(); chk_state("ldi_00", 8'h06, 8'h00, 1'b1, 1'b0);
        tick(); chk_state("jz_taken", 8'h40, 8'h00, 1'b1, 1'b0);
        tick(); chk_state("jc_not", 8'h41, 8'h00, 1'b1, 1'b0);
        tick(); chk_state("not", 8'h42, 8'hFF, 1'b0, 1'b0);
        expect_mem(8'h11, 1'b1, 8'h00);
        tick(); chk_mem_issue("addovf_issue");
        tick(); chk_state("add_ovf", 8'h43, 8'h00, 1'b1, 1'b1);
        tick(); chk_state("jc_taken", 8'h50, 8'h00, 1'b1, 1'b1);
        expect_mem(8'h11, 1'b1, 8'h00);
        tick(); chk_mem_issue("subb_issue");
        tick(); chk_state("sub_borrow", 8'h51, 8'hFF, 1'b0, 1'b1);
        expect_mem(8'h12, 1'b1, 8'h00);
        tick(); chk_mem_issue("lda_issue");
        tick(); chk_state("lda", 8'h52, 8'h00, 1'b1, 1'b1);
        expect_mem(8'h10, 1'b1, 8'h00);
        tick(); chk_mem_issue("abort_issue");

        // Mid-access reset, then nested CALL/RET and stack overflow.
        reset_assert("mid_rst");
        clear_rom();
        rom[8'h00] = 12'h910;
        rom[8'h10] = 12'hC20;
        rom[8'h20] = 12'hC30;
        rom[8'h30] = 12'hC40;
        rom[8'h40] = 12'hC50;
        rom[8'h50] = 12'hD00;
        rom[8'h41] = 12'hD00;
        rom[8'h31] = 12'hD00;
        rom[8'h21] = 12'hD00;
        rom[8'h11] = 12'hC60;
        rom[8'h60] = 12'hC61;
        rom[8'h61] = 12'hC62;
        rom[8'h62] = 12'hC63;
        rom[8'h63] = 12'hC64;
        reset_release("mid_rst");
        for (int i = 0; i < 13; i++) begin
            tick();
            chk("call_trace", 32'({Halted, Direccion_Instrucciones}), 32'({1'b0, call_trace[i]}));
        end
        tick();
        chk("ovf_err", 32'({Stack_Err, Halted}), 32'(2'b11));
        chk("ovf_pc", 32'(Direccion_Instrucciones), 32'(8'h63));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ovf_frozen", 32'({Stack_Err, Halted, Direccion_Instrucciones}), 32'({2'b11, 8'h63}));
        end

        reset_assert("rst_ret");
        clear_rom();
        rom[8'h00] = 12'hD00;
        reset_release("rst_ret");
        tick();
        chk("udf_err", 32'({Stack_Err, Halted, Direccion_Instrucciones}), 32'({2'b11, 8'h00}));

        reset_assert("rst_wrap");
        clear_rom();
        rom[8'h00] = 12'h9FF;
        reset_release("rst_wrap");
        tick(); chk("jmp_ff", 32'(Direccion_Instrucciones), 32'(8'hFF));
        tick(); chk("nop_wrap", 32'(Direccion_Instrucciones), 32'(8'h00));
        rom[8'hFF] = 12'hC80;
        rom[8'h80] = 12'hD00;
        tick(); chk("jmp_ff2", 32'(Direccion_Instrucciones), 32'(8'hFF));
        tick(); chk("call_max", 32'(Direccion_Instrucciones), 32'(8'h80));
        tick(); chk("ret_wrap", 32'({Stack_Err, Direccion_Instrucciones}), 32'({1'b0, 8'h00}));
        rom[8'h00] = 12'hF00;
        Mem_Ack = 1'b1;
        tick(); chk("halt", 32'({Halted, Mem_Req, Direccion_Instrucciones}), 32'({2'b10, 8'h00}));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_hold", 32'({Halted, Mem_Req, Stack_Err, Direccion_Instrucciones}),
                32'({3'b100, 8'h00}));
        end

        chk("sb_drained", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
